// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register map,
// TCON bit positions and the bus address decoder.
package timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [31:0] TH_OFF   = 32'd0;
    localparam logic [31:0] TL_OFF   = 32'd4;
    localparam logic [31:0] TCON_OFF = 32'd8;

    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IS  = 2;
    localparam int TCON_OVR = 3;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON
    } reg_sel_e;

    // Exact word match only; misaligned or unmapped addresses select nothing.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr == base + TH_OFF)        sel = SEL_TH;
            else if (addr == base + TL_OFF)   sel = SEL_TL;
            else if (addr == base + TCON_OFF) sel = SEL_TCON;
        end
        return sel;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE enabled cycles; held at 0 while disabled.
// Tick is combinational from the count register; with PRESCALE=1 tick follows en.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/timer_irq_source.sv
// Bus-mapped reload timer raising a level interrupt on TL overflow; writes land
// at the edge ending the bus cycle, reads are combinational, no backpressure.
module timer_irq_source
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] rdata,
    output logic        irq
);

    reg_sel_e    w_sel;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;
    logic        w_set_is;
    logic        w_set_ovr;
    logic [3:0]  w_tcon_nxt;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [3:0]  r_tcon;
    logic        r_irq;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (r_tcon[TCON_EN]),
        .tick  (w_tick)
    );

    assign w_sel     = decode_addr(addr, BASE_ADDR);
    assign w_wr_th   = mem_wr && (w_sel == SEL_TH);
    assign w_wr_tl   = mem_wr && (w_sel == SEL_TL);
    assign w_wr_tcon = mem_wr && (w_sel == SEL_TCON);

    // A TL write swallows the tick, so it can never also signal an overflow.
    assign w_ovf     = w_tick && !w_wr_tl && (r_tl == 32'hFFFF_FFFF);
    assign w_set_is  = w_ovf && r_tcon[TCON_IE];
    assign w_set_ovr = w_set_is && r_tcon[TCON_IS];

    // Overflow sets beat software clears so an interrupt is never lost.
    always_comb begin
        w_tcon_nxt = r_tcon;
        if (w_wr_tcon) w_tcon_nxt = wdata[3:0];
        if (w_set_is)  w_tcon_nxt[TCON_IS]  = 1'b1;
        if (w_set_ovr) w_tcon_nxt[TCON_OVR] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr_th) r_th <= wdata;
            if (w_wr_tl) begin
                r_tl <= wdata;
            end else if (w_tick) begin
                r_tl <= w_ovf ? r_th : r_tl + 32'd1;
            end
            r_tcon <= w_tcon_nxt;
            r_irq  <= w_tcon_nxt[TCON_IE] & w_tcon_nxt[TCON_IS];
        end
    end

    always_comb begin
        rdata = '0;
        if (mem_rd) begin
            case (w_sel)
                SEL_TH:   rdata = r_th;
                SEL_TL:   rdata = r_tl;
                SEL_TCON: rdata = {28'd0, r_tcon};
                default:  rdata = '0;
            endcase
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: two instances (PRESCALE 1 and 4) share one bus and
// are checked against directed constants and a behavioural register model.
module tb_timer_irq_source;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;
    localparam int PS [2] = '{1, 4};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        irq1, irq4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata1), .irq(irq1)
    );

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .rdata(rdata4), .irq(irq4)
    );

    // Reference model: the register file as plain variables, one set per instance.
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    bit          m_en [2], m_ie [2], m_is [2], m_ovr [2];
    int          m_pc [2];
    bit          mh_th, mh_tl, mh_tc, mtick, movf, mset_is, mset_ovr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_th[d] = '0; m_tl[d] = '0; m_pc[d] = 0;
                m_en[d] = 0; m_ie[d] = 0; m_is[d] = 0; m_ovr[d] = 0;
            end
        end else begin
            mh_th = mem_wr && (addr == A_TH);
            mh_tl = mem_wr && (addr == A_TL);
            mh_tc = mem_wr && (addr == A_TC);
            for (int d = 0; d < 2; d++) begin
                mtick    = m_en[d] && (m_pc[d] == PS[d] - 1);
                m_pc[d]  = m_en[d] ? (m_pc[d] + 1) % PS[d] : 0;
                movf     = mtick && !mh_tl && (m_tl[d] == 32'hFFFF_FFFF);
                mset_is  = movf && m_ie[d];
                mset_ovr = mset_is && m_is[d];
                if (mh_tl)      m_tl[d] = wdata;
                else if (mtick) m_tl[d] = (m_tl[d] == 32'hFFFF_FFFF) ? m_th[d] : m_tl[d] + 32'd1;
                if (mh_th) m_th[d] = wdata;
                if (mh_tc) begin
                    m_en[d] = wdata[0]; m_ie[d] = wdata[1];
                    m_is[d] = wdata[2]; m_ovr[d] = wdata[3];
                end
                if (mset_is)  m_is[d]  = 1;
                if (mset_ovr) m_ovr[d] = 1;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int d);
        if (!mem_rd)          return 32'h0;
        if (addr == A_TH)     return m_th[d];
        if (addr == A_TL)     return m_tl[d];
        if (addr == A_TC)     return {28'd0, m_ovr[d], m_is[d], m_ie[d], m_en[d]};
        return 32'h0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        addr = a; wdata = v; mem_wr = 1'b1; mem_rd = 1'b0;
        cyc();
        mem_wr = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v1, output logic [31:0] v4);
        addr = a; mem_rd = 1'b1; mem_wr = 1'b0;
        #1;
        v1 = rdata1; v4 = rdata4;
        mem_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v1, v4;
        cyc(); cyc();
        checks++;
        if (irq1 !== 1'b0 || irq4 !== 1'b0) begin
            errors++; $display("FAIL reset_hold_irq got=%b/%b exp=0/0", irq1, irq4);
        end
        reset = 1'b1;
        cyc();
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TC, 32'h3);
        cyc();
        checks++;
        if (irq1 !== 1'b1) begin
            errors++; $display("FAIL reset_pre_irq got=%b exp=1", irq1);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (irq1 !== 1'b0 || irq4 !== 1'b0) begin
            errors++; $display("FAIL reset_async_irq got=%b/%b exp=0/0", irq1, irq4);
        end
        cyc();
        reset = 1'b1;
        peek(A_TH, v1, v4);
        checks++;
        if (v1 !== 32'h0 || v4 !== 32'h0) begin
            errors++; $display("FAIL reset_th got=%h/%h exp=0", v1, v4);
        end
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'h0 || v4 !== 32'h0) begin
            errors++; $display("FAIL reset_tl got=%h/%h exp=0", v1, v4);
        end
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'h0 || v4 !== 32'h0) begin
            errors++; $display("FAIL reset_tcon got=%h/%h exp=0", v1, v4);
        end
    endtask

    task automatic test_basic_overflow();
        logic [31:0] v1, v4;
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'h3);
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'hFFFF_FFFE || irq1 !== 1'b0) begin
            errors++; $display("FAIL ovf_start tl=%h irq=%b exp tl=fffffffe irq=0", v1, irq1);
        end
        cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'hFFFF_FFFF || irq1 !== 1'b0) begin
            errors++; $display("FAIL ovf_first tl=%h irq=%b exp tl=ffffffff irq=0", v1, irq1);
        end
        cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'hFFFF_FFFC || irq1 !== 1'b1) begin
            errors++; $display("FAIL ovf_reload tl=%h irq=%b exp tl=fffffffc irq=1", v1, irq1);
        end
        repeat (3) cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL ovf_period_pre tl=%h exp=ffffffff", v1);
        end
        cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL ovf_period tl=%h exp=fffffffc", v1);
        end
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'hF) begin
            errors++; $display("FAIL overrun_tcon got=%h exp=f", v1);
        end
        wr(A_TC, 32'h3);
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'h3 || irq1 !== 1'b0) begin
            errors++; $display("FAIL overrun_clear tcon=%h irq=%b exp tcon=3 irq=0", v1, irq1);
        end
    endtask

    task automatic test_collisions();
        logic [31:0] v1, v4;
        repeat (3) cyc();
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'h7 || irq1 !== 1'b1) begin
            errors++; $display("FAIL coll_set tcon=%h irq=%b exp tcon=7 irq=1", v1, irq1);
        end
        repeat (3) cyc();
        wr(A_TC, 32'h3);
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'hF || irq1 !== 1'b1) begin
            errors++; $display("FAIL coll_tcon tcon=%h irq=%b exp tcon=f irq=1", v1, irq1);
        end
        wr(A_TL, 32'h10);
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'h10) begin
            errors++; $display("FAIL coll_tl got=%h exp=10", v1);
        end
        cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'h11) begin
            errors++; $display("FAIL coll_tl_next got=%h exp=11", v1);
        end
        wr(A_TC, 32'h0);
    endtask

    task automatic test_prescaler();
        logic [31:0] v1, v4;
        wr(A_TL, 32'h0);
        wr(A_TC, 32'h1);
        repeat (12) cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v4 !== 32'h3) begin
            errors++; $display("FAIL presc_12 got=%h exp=3", v4);
        end
        wr(A_TC, 32'h0);
        repeat (5) cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v4 !== 32'h3) begin
            errors++; $display("FAIL presc_hold got=%h exp=3", v4);
        end
        wr(A_TC, 32'h1);
        repeat (3) cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v4 !== 32'h3) begin
            errors++; $display("FAIL presc_restart_early got=%h exp=3", v4);
        end
        cyc();
        peek(A_TL, v1, v4);
        checks++;
        if (v4 !== 32'h4) begin
            errors++; $display("FAIL presc_restart got=%h exp=4", v4);
        end
        wr(A_TC, 32'h0);
    endtask

    task automatic test_decode();
        logic [31:0] v1, v4;
        wr(A_TH, 32'hA5A5_A5A5);
        wr(A_TL, 32'h0000_1234);
        wr(BASE + 32'd12, 32'hFFFF_FFFF);
        wr(BASE + 32'd2, 32'hFFFF_FFFF);
        wr(BASE + 32'd6, 32'hFFFF_FFFF);
        peek(A_TH, v1, v4);
        checks++;
        if (v1 !== 32'hA5A5_A5A5 || v4 !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL dec_th got=%h/%h exp=a5a5a5a5", v1, v4);
        end
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'h1234 || v4 !== 32'h1234) begin
            errors++; $display("FAIL dec_tl got=%h/%h exp=1234", v1, v4);
        end
        peek(A_TC, v1, v4);
        checks++;
        if (v1 !== 32'h0 || v4 !== 32'h0) begin
            errors++; $display("FAIL dec_tcon got=%h/%h exp=0", v1, v4);
        end
        peek(BASE + 32'd12, v1, v4);
        checks++;
        if (v1 !== 32'h0) begin
            errors++; $display("FAIL dec_rd_unmapped got=%h exp=0", v1);
        end
        peek(BASE + 32'd2, v1, v4);
        checks++;
        if (v1 !== 32'h0) begin
            errors++; $display("FAIL dec_rd_misaligned got=%h exp=0", v1);
        end
        addr = A_TH; mem_rd = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++; $display("FAIL dec_no_rd got=%h exp=0", rdata1);
        end
        addr = A_TL; wdata = 32'h5555; mem_wr = 1'b1; mem_rd = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'h1234) begin
            errors++; $display("FAIL rdwr_old got=%h exp=1234", rdata1);
        end
        cyc();
        mem_wr = 1'b0; mem_rd = 1'b0;
        peek(A_TL, v1, v4);
        checks++;
        if (v1 !== 32'h5555) begin
            errors++; $display("FAIL rdwr_new got=%h exp=5555", v1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: a = A_TH;
                1: a = A_TL;
                2: a = A_TC;
                3: a = BASE + 32'd12;
                4: a = BASE + 32'd2;
                default: a = $urandom;
            endcase
            addr   = a;
            mem_wr = ($urandom_range(0, 3) == 0);
            mem_rd = ($urandom_range(0, 1) == 1);
            if (a == A_TC) begin
                wdata    = $urandom;
                wdata[0] = ($urandom_range(0, 7) != 0);
            end else if ($urandom_range(0, 3) != 0) begin
                wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end else begin
                wdata = $urandom;
            end
            #2;
            checks++;
            if (rdata1 !== exp_rd(0)) begin
                errors++; $display("FAIL rnd_rdata1 n=%0d got=%h exp=%h", n, rdata1, exp_rd(0));
            end
            checks++;
            if (rdata4 !== exp_rd(1)) begin
                errors++; $display("FAIL rnd_rdata4 n=%0d got=%h exp=%h", n, rdata4, exp_rd(1));
            end
            checks++;
            if (irq1 !== (m_ie[0] & m_is[0])) begin
                errors++; $display("FAIL rnd_irq1 n=%0d got=%b exp=%b", n, irq1, m_ie[0] & m_is[0]);
            end
            checks++;
            if (irq4 !== (m_ie[1] & m_is[1])) begin
                errors++; $display("FAIL rnd_irq4 n=%0d got=%b exp=%b", n, irq4, m_ie[1] & m_is[1]);
            end
            cyc();
        end
        mem_wr = 1'b0; mem_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_overflow();
        test_collisions();
        test_prescaler();
        test_decode();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
